// File: rtl/stoch_decorr_arr.sv
// Array of NUM_ROWS x NUM_COLS bit-conserving stochastic decorrelators.
// Each lane buffers input ones in a saturating counter and re-emits them at LFSR-chosen times.
module stoch_decorr_arr #(
  parameter int unsigned     NUM_ROWS   = 2,
  parameter int unsigned     NUM_COLS   = 2,
  parameter int unsigned     LFSR_WIDTH = 16,
  parameter int unsigned     CNT_WIDTH  = 4,
  parameter longint unsigned SEED       = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               en,
  input  logic                               bypass,
  input  logic                               flush,
  input  logic [NUM_ROWS-1:0][NUM_COLS-1:0]  A,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  Y,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0]  ovf,
  output logic                               busy
);

  // Tap masks: tap n of the polynomial maps to state bit n-1.
  localparam logic [63:0] TAPS64 =
    (LFSR_WIDTH == 8)  ? 64'h0000_0000_0000_00B8 :
    (LFSR_WIDTH == 16) ? 64'h0000_0000_0000_D008 :
    (LFSR_WIDTH == 32) ? 64'h0000_0000_8020_0003 :
                         64'hD800_0000_0000_0000;
  localparam logic [LFSR_WIDTH-1:0] TAP_MASK = TAPS64[LFSR_WIDTH-1:0];
  localparam logic [CNT_WIDTH:0]    CNT_MAX  = {1'b0, {CNT_WIDTH{1'b1}}};

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0][CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                 y_q, y_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0]                 ovf_q, ovf_d;
  logic                                              busy_q, busy_d;

  logic [CNT_WIDTH:0] ce, nxt, r;
  logic               y_bit;

  // Reset asserts asynchronously and releases two clocks after RST falls.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rst_sync_q <= '1;
    else     rst_sync_q <= rst_sync_d;
  end

  assign rst_int = rst_sync_q[1];

  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    y_d    = y_q;
    ovf_d  = ovf_q;
    ce     = '0;
    nxt    = '0;
    r      = '0;
    y_bit  = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      for (int unsigned j = 0; j < NUM_COLS; j++) begin
        r     = {1'b0, lfsr_q[i][j][CNT_WIDTH-1:0]};
        ce    = {1'b0, cnt_q[i][j]} + (CNT_WIDTH+1)'(A[i][j]);
        y_bit = 1'b0;
        nxt   = '0;
        if (en) begin
          lfsr_d[i][j] = {lfsr_q[i][j][LFSR_WIDTH-2:0], ^(lfsr_q[i][j] & TAP_MASK)};
          if (bypass) begin
            y_d[i][j] = A[i][j];
          end else if (flush) begin
            y_bit        = |cnt_q[i][j];
            y_d[i][j]    = y_bit;
            cnt_d[i][j]  = cnt_q[i][j] - CNT_WIDTH'(y_bit);
          end else begin
            y_bit     = (ce != '0) && (r < ce);
            y_d[i][j] = y_bit;
            nxt       = ce - (CNT_WIDTH+1)'(y_bit);
            if (nxt > CNT_MAX) begin
              cnt_d[i][j] = CNT_MAX[CNT_WIDTH-1:0];
              ovf_d[i][j] = 1'b1;
            end else begin
              cnt_d[i][j] = nxt[CNT_WIDTH-1:0];
            end
          end
        end
      end
    end
    busy_d = |cnt_d;
  end

  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      cnt_q  <= '0;
      y_q    <= '0;
      ovf_q  <= '0;
      busy_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        for (int unsigned j = 0; j < NUM_COLS; j++) begin
          lfsr_q[i][j] <= LFSR_WIDTH'(SEED + longint'(i * NUM_COLS + j));
        end
      end
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
    end
  end

  assign Y    = y_q;
  assign ovf  = ovf_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_stoch_decorr_arr.sv
// Randomised bench for stoch_decorr_arr: two configurations checked cycle by cycle
// against an arithmetic lane model, plus conservation, flush, bypass and SCC checks.
module tb_stoch_decorr_arr;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic             RST = 1'b1;
  logic             en = 1'b0, bypass = 1'b0, flush = 1'b0;
  logic [1:0][1:0]  A = '0;
  logic [1:0][1:0]  y1, o1, y2, o2;
  logic             b1, b2;
  logic [3:0]       y1v, o1v, y2v, o2v;

  assign y1v = y1;
  assign o1v = o1;
  assign y2v = y2;
  assign o2v = o2;

  stoch_decorr_arr #(.NUM_ROWS(2), .NUM_COLS(2), .LFSR_WIDTH(16), .CNT_WIDTH(4),
                     .SEED(64'hACE1)) u_dut (
    .CLK(CLK), .RST(RST), .en(en), .bypass(bypass), .flush(flush),
    .A(A), .Y(y1), .ovf(o1), .busy(b1));

  stoch_decorr_arr #(.NUM_ROWS(2), .NUM_COLS(2), .LFSR_WIDTH(8), .CNT_WIDTH(2),
                     .SEED(64'h35)) u_dut_w2 (
    .CLK(CLK), .RST(RST), .en(en), .bypass(bypass), .flush(flush),
    .A(A), .Y(y2), .ovf(o2), .busy(b2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: instance 0 = (LFSR 16, CNT 4), instance 1 = (LFSR 8, CNT 2)
  int unsigned     lw[2]   = '{16, 8};
  int unsigned     cw[2]   = '{4, 2};
  longint unsigned seed[2] = '{64'hACE1, 64'h35};
  longint unsigned m_lfsr[2][4];
  int unsigned     m_cnt[2][4];
  bit              m_y[2][4];
  bit              m_ovf[2][4];
  int unsigned     m_drop[2][4];

  function automatic longint unsigned lfsr_next(longint unsigned s, int unsigned w);
    int unsigned     t0, t1, t2, t3;
    bit              fb;
    longint unsigned mask;
    case (w)
      8:       begin t0 = 8;  t1 = 6;  t2 = 5;  t3 = 4;  end
      16:      begin t0 = 16; t1 = 15; t2 = 13; t3 = 4;  end
      32:      begin t0 = 32; t1 = 22; t2 = 2;  t3 = 1;  end
      default: begin t0 = 64; t1 = 63; t2 = 61; t3 = 60; end
    endcase
    fb   = s[t0-1] ^ s[t1-1] ^ s[t2-1] ^ s[t3-1];
    mask = (w == 64) ? '1 : ((64'h1 << w) - 1);
    return ((s << 1) | longint'(fb)) & mask;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 4; k++) begin
        m_lfsr[m][k] = (seed[m] + longint'(k)) & ((64'h1 << lw[m]) - 1);
        m_cnt[m][k]  = 0;
        m_y[m][k]    = 1'b0;
        m_ovf[m][k]  = 1'b0;
      end
  endfunction

  function automatic void model_step(input logic [3:0] a, input bit e, input bit b, input bit f);
    int unsigned r, ce, nc, mx;
    if (!e) return;
    for (int m = 0; m < 2; m++) begin
      mx = (1 << cw[m]) - 1;
      for (int k = 0; k < 4; k++) begin
        r = int'(m_lfsr[m][k] & longint'(mx));
        if (b) begin
          m_y[m][k] = a[k];
        end else if (f) begin
          m_y[m][k] = (m_cnt[m][k] != 0);
          if (m_y[m][k]) m_cnt[m][k] = m_cnt[m][k] - 1;
        end else begin
          ce = m_cnt[m][k] + (a[k] ? 1 : 0);
          m_y[m][k] = (ce != 0) && (r < ce);
          nc = ce - (m_y[m][k] ? 1 : 0);
          if (nc > mx) begin
            nc = mx;
            m_ovf[m][k] = 1'b1;
            m_drop[m][k]++;
          end
          m_cnt[m][k] = nc;
        end
        m_lfsr[m][k] = lfsr_next(m_lfsr[m][k], lw[m]);
      end
    end
  endfunction

  function automatic logic [3:0] exp_y(int m);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_y[m][k];
    return v;
  endfunction

  function automatic logic [3:0] exp_ovf(int m);
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_ovf[m][k];
    return v;
  endfunction

  function automatic logic exp_busy(int m);
    logic v = 1'b0;
    for (int k = 0; k < 4; k++) if (m_cnt[m][k] != 0) v = 1'b1;
    return v;
  endfunction

  task automatic compare_all();
    check("y_w4",    64'(y1v), 64'(exp_y(0)));
    check("ovf_w4",  64'(o1v), 64'(exp_ovf(0)));
    check("busy_w4", 64'(b1),  64'(exp_busy(0)));
    check("y_w2",    64'(y2v), 64'(exp_y(1)));
    check("ovf_w2",  64'(o2v), 64'(exp_ovf(1)));
    check("busy_w2", 64'(b2),  64'(exp_busy(1)));
  endtask

  task automatic tick(input logic [3:0] a, input bit e, input bit b, input bit f);
    A = a; en = e; bypass = b; flush = f;
    @(posedge CLK);
    model_step(a, e, b, f);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    RST = 1'b1; en = 1'b0; bypass = 1'b0; flush = 1'b0;
    #1;
    check("rst_async_y", 64'(y1v), 64'h0);
    model_reset();
    for (int n = 0; n < 3; n++) begin
      A = 4'($urandom);
      @(posedge CLK);
      #1;
      compare_all();
    end
    RST = 1'b0;
    for (int n = 0; n < 3; n++) tick(4'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  function automatic real scc(real a, real b, real c, real d);
    real n, num, den, pa, pc;
    n   = a + b + c + d;
    num = a * d - b * c;
    pa  = a + b;
    pc  = a + c;
    if (num > 0.0) den = n * ((pa < pc) ? pa : pc) - pa * pc;
    else           den = pa * pc - n * (((a - d) > 0.0) ? (a - d) : 0.0);
    if (den == 0.0) return 0.0;
    return num / den;
  endfunction

  initial begin
    int ones, pend;
    int lane_ones[4];
    int pend_l[4];
    int cnt_a[6], cnt_b[6], cnt_c[6], cnt_d[6];
    int p_x[6] = '{0, 0, 0, 1, 1, 2};
    int p_z[6] = '{1, 2, 3, 2, 3, 3};
    logic [3:0] a, y_hold;
    real s;

    // Reset behaviour and idle stream
    do_reset();
    for (int n = 0; n < 100; n++) tick(4'h0, 1'b1, 1'b0, 1'b0);
    check("idle_busy", 64'(b1), 64'h0);

    // Lane (0,0) held at 1 for 1000 cycles, then drained: ones conserved
    for (int k = 0; k < 4; k++) m_drop[0][k] = 0;
    ones = 0;
    for (int n = 0; n < 1000; n++) begin
      tick({3'($urandom), 1'b1}, 1'b1, 1'b0, 1'b0);
      ones += int'(y1v[0]);
    end
    for (int n = 0; n < 40; n++) begin
      tick(4'h0, 1'b1, 1'b0, 1'b1);
      ones += int'(y1v[0]);
    end
    check("conserve", 64'(ones), 64'(1000 - m_drop[0][0]));
    check("ovf_clip", 64'(o1v[0]), 64'(m_drop[0][0] != 0));
    check("drain_busy", 64'(b1), 64'h0);

    // Load a few ones on lane 0 then flush them out one per cycle
    for (int n = 0; n < 5; n++) tick(4'h1, 1'b1, 1'b0, 1'b0);
    pend = int'(m_cnt[0][0]);
    ones = 0;
    for (int n = 0; n < 20; n++) begin
      tick(4'h0, 1'b1, 1'b0, 1'b1);
      ones += int'(y1v[0]);
    end
    check("flush_ones", 64'(ones), 64'(pend));
    check("flush_idle", 64'(b1), 64'h0);

    // Identical 50% stream into every lane: pairwise SCC must stay small
    for (int p = 0; p < 6; p++) begin cnt_a[p] = 0; cnt_b[p] = 0; cnt_c[p] = 0; cnt_d[p] = 0; end
    for (int n = 0; n < 4096; n++) begin
      a = {4{1'($urandom)}};
      tick(a, 1'b1, 1'b0, 1'b0);
      for (int p = 0; p < 6; p++) begin
        case ({y1v[p_x[p]], y1v[p_z[p]]})
          2'b11:   cnt_a[p]++;
          2'b10:   cnt_b[p]++;
          2'b01:   cnt_c[p]++;
          default: cnt_d[p]++;
        endcase
      end
    end
    for (int p = 0; p < 6; p++) begin
      s = scc(real'(cnt_a[p]), real'(cnt_b[p]), real'(cnt_c[p]), real'(cnt_d[p]));
      check($sformatf("scc_%0d%0d", p_x[p], p_z[p]), 64'((s < 0.1) && (s > -0.1)), 64'h1);
    end

    // Bypass: Y follows A with one register stage, counters frozen
    for (int n = 0; n < 10; n++) tick(4'hF, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) pend_l[k] = int'(m_cnt[0][k]);
    for (int n = 0; n < 20; n++) begin
      a = (n % 2 == 0) ? 4'hF : 4'h0;
      tick(a, 1'b1, 1'b1, (n % 3 == 0));
      check("byp_y", 64'(y1v), 64'(a));
    end
    for (int k = 0; k < 4; k++) lane_ones[k] = 0;
    for (int n = 0; n < 20; n++) begin
      tick(4'h0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) lane_ones[k] += int'(y1v[k]);
    end
    for (int k = 0; k < 4; k++) check($sformatf("byp_hold_%0d", k), 64'(lane_ones[k]), 64'(pend_l[k]));

    // Narrow-counter streaming, then en=0 must freeze everything
    for (int n = 0; n < 50; n++) tick(4'hF, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) tick(4'h0, 1'b1, 1'b0, 1'b0);
    y_hold = y1v;
    for (int n = 0; n < 10; n++) begin
      tick(4'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      check("en0_hold", 64'(y1v), 64'(y_hold));
    end
    for (int n = 0; n < 50; n++) tick(4'($urandom), 1'b1, 1'b0, 1'b0);

    // Random control mix with a reset in mid-stream
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      tick(4'($urandom), ($urandom % 4) != 0, ($urandom % 10) == 0, ($urandom % 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
